// File: rtl/bcd_updown_counter_ndigit.sv
// N-digit packed-BCD up/down counter with parallel load and wrap/saturate limits.
// Each step ripples digit-serially from the LS digit; the count is published only when complete.
module bcd_updown_counter_ndigit #(
    parameter int COUNTER_DIGITS = 6,
    parameter bit WRAP_MODE      = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        up,
    input  logic                        load,
    input  logic [4*COUNTER_DIGITS-1:0] loadValue,
    output logic                        ready,
    output logic [4*COUNTER_DIGITS-1:0] countValue,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int COUNTER_BITWIDTH     = 4 * COUNTER_DIGITS;
    localparam int DIGIT_INDEX_BITWIDTH = $clog2(COUNTER_DIGITS + 1);
    localparam logic [DIGIT_INDEX_BITWIDTH-1:0] LAST_IDX = DIGIT_INDEX_BITWIDTH'(COUNTER_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_PROCESS,
        S_UPDATE
    } state_e;

    state_e                            state_q, state_d;
    logic                              ready_q, ready_d;
    logic [COUNTER_BITWIDTH-1:0]       count_q, count_d;
    logic [COUNTER_BITWIDTH-1:0]       work_q, work_d;
    logic                              carry_q, carry_d;
    logic                              up_q, up_d;
    logic [DIGIT_INDEX_BITWIDTH-1:0]   idx_q, idx_d;
    logic                              overflow_q, overflow_d;
    logic                              underflow_q, underflow_d;

    function automatic logic [COUNTER_BITWIDTH-1:0] clamp_bcd(input logic [COUNTER_BITWIDTH-1:0] v);
        logic [COUNTER_BITWIDTH-1:0] r;
        r = v;
        for (int d = 0; d < COUNTER_DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'd9;
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        ready_d     = ready_q;
        count_d     = count_q;
        work_d      = work_q;
        carry_d     = carry_q;
        up_d        = up_q;
        idx_d       = idx_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Re-arm only once both requests drop, so a held enable steps once.
                if (!(enable || load)) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end
            end
            S_READY: begin
                if (load) begin
                    ready_d = 1'b0;
                    work_d  = clamp_bcd(loadValue);
                    carry_d = 1'b0;
                    state_d = S_UPDATE;
                end else if (enable) begin
                    ready_d = 1'b0;
                    up_d    = up;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = S_PROCESS;
                end
            end
            S_PROCESS: begin
                for (int d = 0; d < COUNTER_DIGITS; d++) begin
                    if (idx_q == DIGIT_INDEX_BITWIDTH'(d)) begin
                        if (up_q) begin
                            if (carry_q && work_q[4*d +: 4] == 4'd9) begin
                                work_d[4*d +: 4] = 4'd0;
                            end else begin
                                work_d[4*d +: 4] = work_q[4*d +: 4] + {3'b000, carry_q};
                                carry_d          = 1'b0;
                            end
                        end else begin
                            if (carry_q && work_q[4*d +: 4] == 4'd0) begin
                                work_d[4*d +: 4] = 4'd9;
                            end else begin
                                work_d[4*d +: 4] = work_q[4*d +: 4] - {3'b000, carry_q};
                                carry_d          = 1'b0;
                            end
                        end
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (carry_q) begin
                    // Saturation keeps the published value and resyncs the working copy to it.
                    if (WRAP_MODE) count_d = work_q;
                    else           work_d  = count_q;
                    if (up_q) overflow_d  = 1'b1;
                    else      underflow_d = 1'b1;
                end else begin
                    count_d = work_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            count_q     <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            up_q        <= 1'b0;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            count_q     <= count_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            up_q        <= up_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign ready      = ready_q;
    assign countValue = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_bcd_updown_counter_ndigit.sv
// Directed bench: a wrapping and a saturating counter share one stimulus stream.
module tb_bcd_updown_counter_ndigit;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        up;
    logic        load;
    logic [23:0] loadValue;
    logic        ready_w, ready_s;
    logic [23:0] count_w, count_s;
    logic        ov_w, ov_s, uf_w, uf_s;

    int checks   = 0;
    int failures = 0;

    bcd_updown_counter_ndigit #(.COUNTER_DIGITS(6), .WRAP_MODE(1'b1)) u_wrap (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .loadValue(loadValue), .ready(ready_w), .countValue(count_w),
        .overflow(ov_w), .underflow(uf_w)
    );

    bcd_updown_counter_ndigit #(.COUNTER_DIGITS(6), .WRAP_MODE(1'b0)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .loadValue(loadValue), .ready(ready_s), .countValue(count_s),
        .overflow(ov_s), .underflow(uf_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40 && !(ready_w && ready_s); i++) tick();
        check({tag, "_ready"}, {30'd0, ready_w, ready_s}, 32'd3);
    endtask

    task automatic do_load(input string tag, input logic [23:0] v, input logic [23:0] exp);
        wait_ready(tag);
        load      = 1'b1;
        loadValue = v;
        tick();
        load = 1'b0;
        tick();
        check({tag, "_count_w"}, count_w, exp);
        check({tag, "_count_s"}, count_s, exp);
    endtask

    task automatic do_step(input string tag, input logic dir,
                           input logic [23:0] exp_w, input logic [23:0] exp_s,
                           input logic [3:0] flags_exp);
        wait_ready(tag);
        enable = 1'b1;
        up     = dir;
        tick();
        enable = 1'b0;
        repeat (7) tick();
        check({tag, "_count_w"}, count_w, exp_w);
        check({tag, "_count_s"}, count_s, exp_s);
        check({tag, "_flags"}, {28'd0, ov_w, uf_w, ov_s, uf_s}, {28'd0, flags_exp});
        tick();
        check({tag, "_flags_end"}, {28'd0, ov_w, uf_w, ov_s, uf_s}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        up        = 1'b1;
        load      = 1'b0;
        loadValue = '0;
        tick();
        tick();
        check("rst_ready", {30'd0, ready_w, ready_s}, 32'd0);
        check("rst_count_w", count_w, 32'd0);
        check("rst_count_s", count_s, 32'd0);
        check("rst_flags", {28'd0, ov_w, uf_w, ov_s, uf_s}, 32'd0);
        reset = 1'b0;
        tick();
        check("arm_ready", {30'd0, ready_w, ready_s}, 32'd3);

        // Single step: result lands on the 7th edge, ready one edge after that.
        enable = 1'b1;
        up     = 1'b1;
        tick();
        enable = 1'b0;
        check("t1_busy", {30'd0, ready_w, ready_s}, 32'd0);
        repeat (6) tick();
        check("t1_e6_count", count_w, 32'd0);
        tick();
        check("t1_e7_count_w", count_w, 32'h000001);
        check("t1_e7_count_s", count_s, 32'h000001);
        check("t1_e7_ready", {30'd0, ready_w, ready_s}, 32'd0);
        tick();
        check("t1_e8_ready", {30'd0, ready_w, ready_s}, 32'd3);

        do_load("t2_load", 24'h000999, 24'h000999);
        do_step("t2_up", 1'b1, 24'h001000, 24'h001000, 4'b0000);

        // flags ordering: {ov_w, uf_w, ov_s, uf_s}
        do_load("t3_load", 24'h999999, 24'h999999);
        do_step("t3_up", 1'b1, 24'h000000, 24'h999999, 4'b1010);
        do_step("t3_down", 1'b0, 24'h999999, 24'h999998, 4'b0100);

        do_load("t4_load", 24'h001000, 24'h001000);
        do_step("t4_down", 1'b0, 24'h000999, 24'h000999, 4'b0000);
        do_load("t4_zero", 24'h000000, 24'h000000);
        do_step("t4_under", 1'b0, 24'h999999, 24'h000000, 4'b0101);

        do_load("t5_base", 24'h000100, 24'h000100);
        wait_ready("t5_hold");
        enable = 1'b1;
        up     = 1'b1;
        repeat (20) tick();
        enable = 1'b0;
        repeat (10) tick();
        check("t5_hold_count_w", count_w, 32'h000101);
        check("t5_hold_count_s", count_s, 32'h000101);
        do_load("t5_clamp", 24'h00C0A5, 24'h009095);
        wait_ready("t5_both");
        load      = 1'b1;
        enable    = 1'b1;
        loadValue = 24'h000042;
        tick();
        load   = 1'b0;
        enable = 1'b0;
        tick();
        check("t5_both_count", count_w, 32'h000042);
        repeat (10) tick();
        check("t5_both_nostep_w", count_w, 32'h000042);
        check("t5_both_nostep_s", count_s, 32'h000042);

        // Reset lands in the third PROCESS cycle.
        do_load("t6_base", 24'h000500, 24'h000500);
        wait_ready("t6_start");
        enable = 1'b1;
        up     = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_count_w", count_w, 32'd0);
        check("t6_rst_count_s", count_s, 32'd0);
        check("t6_rst_ready", {30'd0, ready_w, ready_s}, 32'd0);
        check("t6_rst_flags", {28'd0, ov_w, uf_w, ov_s, uf_s}, 32'd0);
        reset = 1'b0;
        tick();
        do_step("t6_after", 1'b1, 24'h000001, 24'h000001, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
